// File: rtl/seg7_scan_display.sv
// seg7_scan_display: two-digit multiplexed common-anode 7-segment driver.
// Shows a 0..127 binary input as two decimal digits. Values 100..127 show a
// dash on both digits.
// The input is sampled once per scan frame and converted to BCD by
// subtracting 10 repeatedly.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN blanks a leading zero
// in the tens digit.
module seg7_scan_display #(
   parameter int SCAN_DIV = 200000,
   parameter int DIV_W    = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] num,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   typedef enum logic {IDLE, CONV} conv_state_t;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             digit_idx_q, digit_idx_d;
   conv_state_t      state_q, state_d;
   logic [6:0]       rem_q, rem_d;
   logic [3:0]       tacc_q, tacc_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q;
   logic             tick;
   logic             frame_start;

   // Active-low segment pattern for one decimal digit (a = bit 0).
   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign tick        = (div_cnt_q == DIV_LAST);
   assign frame_start = tick & digit_idx_q;

   // Refresh divider and digit slot sequencer.
   always_comb begin
      div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
      digit_idx_d = tick ? ~digit_idx_q : digit_idx_q;
   end

   // Binary-to-BCD conversion. The display registers update only on the
   // commit cycle, so a half-finished result is never shown.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      tacc_d  = tacc_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               rem_d   = num;
               tacc_d  = 4'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            if (rem_q >= 7'd10) begin
               rem_d  = rem_q - 7'd10;
               tacc_d = tacc_q + 4'd1;
            end else begin
               ones_d  = rem_q[3:0];
               tens_d  = tacc_q;
               ovf_d   = (tacc_q >= 4'd10);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Anode and segment patterns for the current slot. They are registered
   // together so that both change on the same edge.
   always_comb begin
      if (!digit_idx_q) begin
         an_d  = 8'hFE;
         seg_d = enc(ones_q);
      end else begin
         an_d  = 8'hFD;
         seg_d = enc(tens_q);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         if (tens_q == 4'd0 && !ovf_q) begin
            seg_d = 7'h7F;
         end
`endif
      end
      if (ovf_q) begin
         seg_d = 7'h3F;
      end
   end

   // All state registers, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q   <= '0;
         digit_idx_q <= 1'b0;
         state_q     <= IDLE;
         rem_q       <= 7'd0;
         tacc_q      <= 4'd0;
         tens_q      <= 4'd0;
         ones_q      <= 4'd0;
         ovf_q       <= 1'b0;
         an_q        <= 8'hFF;
         seg_q       <= 7'h7F;
         dp_q        <= 1'b1;
      end else begin
         div_cnt_q   <= div_cnt_d;
         digit_idx_q <= digit_idx_d;
         state_q     <= state_d;
         rem_q       <= rem_d;
         tacc_q      <= tacc_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         ovf_q       <= ovf_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= 1'b1;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream display stage for the 0..20 button-driven counter; consumes its 7-bit `num` and shows it as two decimal digits on a multiplexed, common-anode 7-segment display.
- Contains:
  - a refresh divider;
  - a 2-digit scan sequencer;
  - a frame-synchronous input sampler;
  - a sequential binary-to-BCD converter (repeated subtract-10);
  - a registered segment encoder.

Parameters:
- SCAN_DIV, 200000, clk cycles per digit slot (2 ms at 100 MHz); legal range >= 16.
- DIV_W, 32, width of the divider counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- num  in  7  unsigned binary value to display (0..127 accepted).
- an   out 8  digit anodes, active-low; an[0]=ones, an[1]=tens, an[7:2] held 1.
- seg  out 7  segments, active-low; seg[0]=a … seg[6]=g.
- dp   out 1  decimal point, active-low; held 1 (off).

Behaviour:
- Reset values (on a clk edge with rst=1):
  - an=8'hFF, seg=7'h7F, dp=1.
  - div_cnt=0, digit_idx=0, conv state=IDLE.
  - tens=0, ones=0, ovf=0.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - tick=1 for one cycle when div_cnt==SCAN_DIV-1.
- Scan:
  - On tick, digit_idx toggles 0<->1.
  - frame_start = tick && digit_idx==1, i.e. the wrap back to the ones slot.
- Outputs are registered from digit_idx and the display regs, so an and seg always change on the same edge (no ghosting):
  - digit_idx=0: an=8'hFE, seg=enc(ones).
  - digit_idx=1: an=8'hFD, seg=enc(tens).
  - If ovf=1, both slots drive seg=7'h3F (dash, g only).
- Encoding, active-low hex, digits 0..9: 40,79,24,30,19,12,02,78,00,10.
- Conversion FSM (states IDLE, CONV):
  - IDLE: on frame_start, rem<=num, tacc<=0, go to CONV. num is sampled only on this edge.
  - CONV, rem>=10: rem<=rem-10, tacc<=tacc+1.
  - CONV, rem<10: ones<=rem[3:0]; tens<=tacc[3:0]; ovf<=(tacc>=10); go to IDLE.
  - Worst case (num=127): 12 subtract cycles + 1 commit cycle = 13 cycles after the sampling edge.
- Display regs (tens, ones, ovf) change only on the commit cycle, so a digit never shows a partial result.
- Boundary conditions:
  - num changes mid-frame: no effect until the next frame_start.
  - frame_start while in CONV: cannot occur for SCAN_DIV>=16; if it did, it is ignored.
  - num 100..127: ovf=1, both digits show dash.
  - rst mid-conversion or mid-scan: all state returns to reset values on that edge. The first conversion after reset starts at the first frame_start (display shows 00 until then).
- Arithmetic: rem is 7 bits and tacc is 4 bits; no wrap is possible for inputs <=127.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: in the tens slot, if tens==0 and ovf==0, seg=7'h7F (blank). an[1] is still asserted so scan timing is unchanged.
- Undefined: the tens slot always shows enc(tens); e.g. value 7 displays "07".

Test Plan (SCAN_DIV=16, macro undefined unless stated):
- Reset behaviour:
  - Stimulus: hold rst 3 cycles, num=0.
  - Response: an=FF, seg=7F, dp=1 while rst=1. After the first tick following release, an=FE, seg=40.
- num=7:
  - Stimulus: num=7 held; wait one frame_start + 13 cycles + 2 slots.
  - Response: ones slot (an=FE) seg=78; tens slot (an=FD) seg=40.
  - With macro defined: tens slot seg=7F.
- num=20 (counter terminal value):
  - Response: tens slot seg=24; ones slot seg=40; commit occurs exactly 3 cycles after sampling (2 subtracts + 1 commit).
- num=127:
  - Response: ovf=1; both slots seg=3F; commit 13 cycles after the sampling edge.
- Mid-frame change:
  - Stimulus: num 5->9 two cycles after a frame_start.
  - Response: ones stays 12 (5) through the current frame; becomes 10 (9) only after the next frame_start + 1 cycle.
- Reset mid-operation:
  - Stimulus: assert rst during CONV with digit_idx=1.
  - Response: next edge an=FF, seg=7F; after release, digit_idx=0, div_cnt restarts from 0, display shows 00 until the next conversion.
